// File: rtl/writeback_scheduler.sv
// Writeback arbiter: ALU/BRU direct, LSU/MUL/DIV through 1-entry holding buffers with aging stall.
// Optional perf counters built when WB_SCHED_PERF_EN is defined.
package wb_sched_pkg;
    typedef struct packed {
        logic        valid;
        logic        wren;
        logic [4:0]  rd;
        logic [31:0] data;
    } pipe_t;
endpackage

module writeback_scheduler
    import wb_sched_pkg::*;
#(
    parameter  int MAX_WAIT = 4,
    localparam int WAIT_W   = $clog2(MAX_WAIT + 1)
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  pipe_t       i_alu_wb_pkg,
    input  pipe_t       i_bru_wb_pkg,
    input  pipe_t       i_lsu_wb_pkg,
    input  pipe_t       i_mul_wb_pkg,
    input  pipe_t       i_div_wb_pkg,
    output logic        o_rdy_lsu,
    output logic        o_rdy_mul,
    output logic        o_rdy_div,
    output logic        o_stall,
    output logic        o_conflict,
    output pipe_t       o_wb_pkg,
    output logic [31:0] o_perf_stall,
    output logic [31:0] o_perf_grant
);

    // Buffer index 0=LSU, 1=MUL, 2=DIV; also the round-robin order.
    pipe_t             in_pkg   [3];
    pipe_t             buf_pkg  [3];
    logic [WAIT_W-1:0] wait_cnt [3];
    logic [2:0]        held;
    logic [2:0]        offer;
    logic [2:0]        starved;
    logic [2:0]        grant;
    logic [2:0]        rdy;
    logic [2:0]        accept;
    logic [1:0]        rr_ptr;
    logic [1:0]        rr_ptr_nxt;
    logic              stall;
    logic              conflict;
    logic              sel_alu;
    logic              sel_bru;
    logic              alu_req;
    logic              bru_req;
    pipe_t             wb_nxt;

    // One-hot grant of the first set mask bit at or after ptr, wrapping DIV->LSU.
    function automatic logic [2:0] rr_pick(input logic [2:0] mask, input logic [1:0] ptr);
        logic [2:0] g;
        logic [2:0] s;
        g = 3'b000;
        for (int k = 2; k >= 0; k--) begin
            s = {1'b0, ptr} + 3'(k);
            if (s >= 3'd3) s = s - 3'd3;
            else           s = s;
            if (mask[s[1:0]]) g = 3'b001 << s[1:0];
            else              g = g;
        end
        return g;
    endfunction

    assign in_pkg[0] = i_lsu_wb_pkg;
    assign in_pkg[1] = i_mul_wb_pkg;
    assign in_pkg[2] = i_div_wb_pkg;
    assign alu_req   = i_alu_wb_pkg.valid & i_alu_wb_pkg.wren;
    assign bru_req   = i_bru_wb_pkg.valid & i_bru_wb_pkg.wren;

    // Starvation depends on registered state only, so o_stall has no input path.
    always_comb begin
        for (int x = 0; x < 3; x++) begin
            offer[x]   = in_pkg[x].valid & in_pkg[x].wren;
            starved[x] = held[x] & (wait_cnt[x] == WAIT_W'(MAX_WAIT));
        end
        stall = |starved;
    end

    // Arbitration: starved buffer, then ALU, then BRU, then round-robin buffers.
    always_comb begin
        grant    = 3'b000;
        sel_alu  = 1'b0;
        sel_bru  = 1'b0;
        conflict = 1'b0;
        if (stall) begin
            grant = rr_pick(starved, rr_ptr);
        end else if (alu_req) begin
            sel_alu  = 1'b1;
            conflict = bru_req;
        end else if (bru_req) begin
            sel_bru = 1'b1;
        end else begin
            grant = rr_pick(held, rr_ptr);
        end
    end

    // Next write package, pointer advance and buffer handshake.
    always_comb begin
        wb_nxt = sel_alu  ? i_alu_wb_pkg :
                 sel_bru  ? i_bru_wb_pkg :
                 grant[0] ? buf_pkg[0]   :
                 grant[1] ? buf_pkg[1]   :
                 grant[2] ? buf_pkg[2]   : '0;
        case (grant)
            3'b001:  rr_ptr_nxt = 2'd1;
            3'b010:  rr_ptr_nxt = 2'd2;
            3'b100:  rr_ptr_nxt = 2'd0;
            default: rr_ptr_nxt = rr_ptr;
        endcase
        rdy    = {3{~i_rst}} & (~held | grant);
        accept = offer & rdy;
    end

    // Holding buffers, aging counters, RR pointer and registered write port.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            held     <= 3'b000;
            rr_ptr   <= 2'd0;
            o_wb_pkg <= '0;
            for (int x = 0; x < 3; x++) begin
                buf_pkg[x]  <= '0;
                wait_cnt[x] <= '0;
            end
        end else begin
            o_wb_pkg <= wb_nxt;
            rr_ptr   <= rr_ptr_nxt;
            for (int x = 0; x < 3; x++) begin
                if (grant[x] | ~held[x]) held[x] <= accept[x];
                else                     held[x] <= held[x];
                if (accept[x]) buf_pkg[x] <= in_pkg[x];
                else           buf_pkg[x] <= buf_pkg[x];
                if (grant[x] | ~held[x])                    wait_cnt[x] <= '0;
                else if (wait_cnt[x] != WAIT_W'(MAX_WAIT))  wait_cnt[x] <= wait_cnt[x] + WAIT_W'(1);
                else                                        wait_cnt[x] <= wait_cnt[x];
            end
        end
    end

    assign o_rdy_lsu  = rdy[0];
    assign o_rdy_mul  = rdy[1];
    assign o_rdy_div  = rdy[2];
    assign o_stall    = stall;
    assign o_conflict = conflict & ~i_rst;

`ifdef WB_SCHED_PERF_EN
    logic [31:0] perf_stall;
    logic [31:0] perf_grant;

    // Free-running wrap-around event counters.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            perf_stall <= 32'd0;
            perf_grant <= 32'd0;
        end else begin
            perf_stall <= perf_stall + {31'd0, stall};
            perf_grant <= perf_grant + {31'd0, |grant};
        end
    end

    assign o_perf_stall = perf_stall;
    assign o_perf_grant = perf_grant;
`else
    assign o_perf_stall = 32'd0;
    assign o_perf_grant = 32'd0;
`endif

endmodule

// File: tb/tb_writeback_scheduler.sv
// Directed bench for writeback_scheduler: latency, round-robin, aging stall, conflict, reset, perf.
module tb_writeback_scheduler;
    import wb_sched_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    pipe_t       alu_pkg, bru_pkg, lsu_pkg, mul_pkg, div_pkg;
    logic        rdy_lsu, rdy_mul, rdy_div, stall, conflict;
    pipe_t       wb_pkg;
    logic [31:0] perf_stall, perf_grant;
    int          checks = 0;
    int          errors = 0;

`ifdef WB_SCHED_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    writeback_scheduler #(.MAX_WAIT(4)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_alu_wb_pkg(alu_pkg), .i_bru_wb_pkg(bru_pkg), .i_lsu_wb_pkg(lsu_pkg),
        .i_mul_wb_pkg(mul_pkg), .i_div_wb_pkg(div_pkg),
        .o_rdy_lsu(rdy_lsu), .o_rdy_mul(rdy_mul), .o_rdy_div(rdy_div),
        .o_stall(stall), .o_conflict(conflict), .o_wb_pkg(wb_pkg),
        .o_perf_stall(perf_stall), .o_perf_grant(perf_grant)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic pipe_t mk(input logic [4:0] rd, input logic [31:0] d);
        return {1'b1, 1'b1, rd, d};
    endfunction

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic idle();
        alu_pkg = '0; bru_pkg = '0; lsu_pkg = '0; mul_pkg = '0; div_pkg = '0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        repeat (2) smp();
        chk("rst_rdy", 64'({rdy_lsu, rdy_mul, rdy_div}), 64'd0);
        chk("rst_wb", 64'(wb_pkg), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_conflict", 64'(conflict), 64'd0);
        chk("rst_perf", 64'({perf_stall, perf_grant}), 64'd0);
        nxt();
        rst = 1'b0;

        // ALU only: written next cycle, buffers stay ready
        alu_pkg = mk(5'd5, 32'h0000_00A5);
        smp();
        chk("alu_rdy", 64'({rdy_lsu, rdy_mul, rdy_div}), 64'd7);
        chk("alu_stall", 64'(stall), 64'd0);
        nxt(); idle(); smp();
        chk("alu_wb", 64'(wb_pkg), 64'(mk(5'd5, 32'h0000_00A5)));

        // MUL offer with idle ALU: written two edges later
        nxt(); mul_pkg = mk(5'd7, 32'h77); smp();
        chk("mul_rdy_t", 64'(rdy_mul), 64'd1);
        nxt(); idle(); smp();
        chk("mul_wb_t1", 64'(wb_pkg), 64'd0);
        nxt(); smp();
        chk("mul_wb_t2", 64'(wb_pkg), 64'(mk(5'd7, 32'h77)));
        chk("mul_rdy_t2", 64'(rdy_mul), 64'd1);

        // Held MUL blocked by ALU, then grant + new offer in the same cycle
        nxt(); mul_pkg = mk(5'd9, 32'h90); alu_pkg = mk(5'd1, 32'h11); smp();
        nxt(); mul_pkg = '0; alu_pkg = mk(5'd2, 32'h22); smp();
        chk("rep_rdy_busy", 64'(rdy_mul), 64'd0);
        chk("rep_wb_alu1", 64'(wb_pkg), 64'(mk(5'd1, 32'h11)));
        nxt(); alu_pkg = '0; mul_pkg = mk(5'd10, 32'hB0); smp();
        chk("rep_rdy_grant", 64'(rdy_mul), 64'd1);
        chk("rep_wb_alu2", 64'(wb_pkg), 64'(mk(5'd2, 32'h22)));
        nxt(); mul_pkg = '0; smp();
        chk("rep_wb_old", 64'(wb_pkg), 64'(mk(5'd9, 32'h90)));
        nxt(); smp();
        chk("rep_wb_new", 64'(wb_pkg), 64'(mk(5'd10, 32'hB0)));
        nxt(); smp();
        chk("rep_wb_empty", 64'(wb_pkg), 64'd0);

        // ALU+BRU conflict, then BRU alone
        nxt(); alu_pkg = mk(5'd3, 32'h33); bru_pkg = mk(5'd4, 32'h44); smp();
        chk("cfl_flag", 64'(conflict), 64'd1);
        nxt(); idle(); smp();
        chk("cfl_wb", 64'(wb_pkg), 64'(mk(5'd3, 32'h33)));
        chk("cfl_clear", 64'(conflict), 64'd0);
        nxt(); bru_pkg = mk(5'd6, 32'h66); smp();
        chk("bru_noconf", 64'(conflict), 64'd0);
        nxt(); idle(); smp();
        chk("bru_wb", 64'(wb_pkg), 64'(mk(5'd6, 32'h66)));

        // Reset while MUL is held discards it
        nxt(); mul_pkg = mk(5'd11, 32'hBB); alu_pkg = mk(5'd12, 32'hCC);
        nxt(); mul_pkg = '0; alu_pkg = mk(5'd13, 32'hDD); smp();
        chk("rh_rdy_busy", 64'(rdy_mul), 64'd0);
        rst = 1'b1;
        #1;
        chk("rh_wb_async", 64'(wb_pkg), 64'd0);
        nxt(); rst = 1'b0; idle(); smp();
        chk("rh_rdy_after", 64'(rdy_mul), 64'd1);
        nxt(); smp();
        chk("rh_no_write", 64'(wb_pkg), 64'd0);

        // DIV starved by continuous ALU traffic: 4 ALU writes, one stall cycle
        nxt(); div_pkg = mk(5'd20, 32'hD0); smp();
        chk("stv_rdy_div", 64'(rdy_div), 64'd1);
        for (int k = 1; k <= 6; k++) begin
            nxt();
            div_pkg = '0;
            alu_pkg = (k <= 4) ? mk(5'(k), 32'(k)) : mk(5'd5, 32'h55);
            smp();
            chk($sformatf("stv_stall_%0d", k), 64'(stall), 64'(k == 5));
            if (k == 1)      chk("stv_wb_1", 64'(wb_pkg), 64'd0);
            else if (k <= 5) chk($sformatf("stv_wb_%0d", k), 64'(wb_pkg), 64'(mk(5'(k - 1), 32'(k - 1))));
            else             chk("stv_wb_div", 64'(wb_pkg), 64'(mk(5'd20, 32'hD0)));
        end
        nxt(); idle(); smp();
        chk("stv_wb_held_alu", 64'(wb_pkg), 64'(mk(5'd5, 32'h55)));
        chk("stv_stall_drop", 64'(stall), 64'd0);

        // Two more buffered grants for the perf totals
        nxt(); lsu_pkg = mk(5'd21, 32'h21); mul_pkg = mk(5'd22, 32'h22); alu_pkg = mk(5'd23, 32'h23);
        nxt(); idle(); smp();
        chk("pf_wb_alu", 64'(wb_pkg), 64'(mk(5'd23, 32'h23)));
        nxt(); smp();
        chk("pf_wb_lsu", 64'(wb_pkg), 64'(mk(5'd21, 32'h21)));
        nxt(); smp();
        chk("pf_wb_mul", 64'(wb_pkg), 64'(mk(5'd22, 32'h22)));
        chk("pf_grant", 64'(perf_grant), PERF ? 64'd3 : 64'd0);
        chk("pf_stall", 64'(perf_stall), PERF ? 64'd1 : 64'd0);

        // Round-robin from LSU after reset: LSU, MUL, DIV on consecutive cycles
        rst = 1'b1;
        nxt(); rst = 1'b0;
        nxt(); lsu_pkg = mk(5'd24, 32'h24); mul_pkg = mk(5'd25, 32'h25);
        div_pkg = mk(5'd26, 32'h26); alu_pkg = mk(5'd30, 32'h30);
        nxt(); idle(); smp();
        chk("rr_wb_alu", 64'(wb_pkg), 64'(mk(5'd30, 32'h30)));
        nxt(); smp();
        chk("rr_wb_lsu", 64'(wb_pkg), 64'(mk(5'd24, 32'h24)));
        nxt(); smp();
        chk("rr_wb_mul", 64'(wb_pkg), 64'(mk(5'd25, 32'h25)));
        nxt(); smp();
        chk("rr_wb_div", 64'(wb_pkg), 64'(mk(5'd26, 32'h26)));
        nxt(); smp();
        chk("rr_wb_empty", 64'(wb_pkg), 64'd0);
        chk("rr_pf_grant", 64'(perf_grant), PERF ? 64'd3 : 64'd0);
        chk("rr_pf_stall", 64'(perf_stall), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
